// File: rtl/i2s_array_rx.sv
// i2s_array_rx: I2S master receiver for N_LINES data lines with framed AXI4-Stream output
module i2s_array_rx #(
  parameter int N_LINES  = 2,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 4,
  parameter int OUT_W    = 32,
  parameter int CH_W     = (2 * N_LINES > 2) ? $clog2(2 * N_LINES) : 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               en,
  input  logic               ovf_clr,
  output logic               sck,
  output logic               ws,
  input  logic [N_LINES-1:0] sd,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic [CH_W-1:0]    m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               overflow,
  output logic [15:0]        ovf_count
);
  localparam int N_CH  = 2 * N_LINES;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_W);

  logic [DIV_W-1:0]           div;
  logic [BIT_W-1:0]           bit_cnt;
  logic [BIT_W-1:0]           pos;
  logic                       en_q;
  logic                       run;
  logic                       tc;
  logic                       sck_q;
  logic                       slot;
  logic                       fall;
  logic                       take;
  logic                       done;
  logic                       last;
  logic                       hs;
  logic                       load;
  logic                       drop;
  logic [N_LINES-1:0]         sd_q;
  logic [SAMPLE_W-1:0]        sh     [N_CH];
  logic [SAMPLE_W-1:0]        sh_nxt [N_CH];
  logic [SAMPLE_W-1:0]        fbuf   [N_CH];
  logic                       full;
  logic [CH_W-1:0]            idx;
  logic signed [SAMPLE_W-1:0] cur;

  assign run  = en && en_q;
  assign tc   = div == DIV_W'(CLK_DIV - 1);
  assign fall = run && sck_q && tc;
  assign slot = bit_cnt >= BIT_W'(SLOT_W);
  assign pos  = slot ? bit_cnt - BIT_W'(SLOT_W) : bit_cnt;
  assign take = fall && pos != '0 && pos <= BIT_W'(SAMPLE_W);
  assign done = take && slot && pos == BIT_W'(SAMPLE_W);
  assign last = idx == CH_W'(N_CH - 1);
  assign hs   = full && m_axis_tready;
  assign load = done && (!full || (hs && last));
  assign drop = done && !load;
  assign cur  = fbuf[idx];

  assign sck           = sck_q;
  assign ws            = slot;
  assign m_axis_tdata  = OUT_W'(cur);
  assign m_axis_tuser  = idx;
  assign m_axis_tlast  = full && last;
  assign m_axis_tvalid = full;

  // next shift-register contents: the active slot of every line takes one bit
  always_comb begin
    for (int c = 0; c < N_CH; c++) sh_nxt[c] = sh[c];
    if (take)
      for (int l = 0; l < N_LINES; l++)
        sh_nxt[2 * l + int'(slot)] = SAMPLE_W'({sh[2 * l + int'(slot)], sd_q[l]});
  end

  // enable edge delay, SCK divider and bit counter; all held cleared while disabled
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q    <= 1'b0;
      div     <= '0;
      sck_q   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      en_q    <= en;
      div     <= (!run || tc) ? '0 : div + 1'b1;
      sck_q   <= run && (tc ? !sck_q : sck_q);
      bit_cnt <= !run ? '0 : !fall ? bit_cnt : bit_cnt == BIT_W'(2 * SLOT_W - 1) ? '0 : bit_cnt + 1'b1;
    end
  end

  // serial data input register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sd_q <= '0;
    else sd_q <= sd;
  end

  // per-channel shift registers, discarded whenever capture is disabled
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn || !run) begin
      for (int c = 0; c < N_CH; c++) sh[c] <= '0;
    end else begin
      sh <= sh_nxt;
    end
  end

  // frame buffer: loads on completion when free, drains one channel per handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < N_CH; c++) fbuf[c] <= '0;
      full <= 1'b0;
      idx  <= '0;
    end else if (load) begin
      fbuf <= sh_nxt;
      full <= 1'b1;
      idx  <= '0;
    end else if (hs) begin
      full <= !last;
      idx  <= last ? '0 : idx + 1'b1;
    end
  end

  // sticky overflow and saturating drop counter; a drop beats a simultaneous clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else if (drop) begin
      overflow  <= 1'b1;
      ovf_count <= ovf_clr ? 16'd1 : ovf_count == 16'hFFFF ? ovf_count : ovf_count + 16'd1;
    end else if (ovf_clr) begin
      overflow  <= 1'b0;
      ovf_count <= '0;
    end
  end
endmodule

// File: tb/tb_i2s_array_rx.sv
// tb_i2s_array_rx: randomized I2S microphone model and stream scoreboard for i2s_array_rx
module tb_i2s_array_rx;
  localparam int NL = 2, SW = 24, SL = 32, CD = 4, OW = 32, CW = 2, NCH = 4;

  logic          aclk = 1'b0;
  logic          aresetn, en, ovf_clr, sck, ws;
  logic [NL-1:0] sd = '0;
  logic [OW-1:0] m_axis_tdata;
  logic [CW-1:0] m_axis_tuser;
  logic          m_axis_tlast, m_axis_tvalid, overflow;
  logic          m_axis_tready = 1'b0;
  logic [15:0]   ovf_count;

  always #5 aclk = ~aclk;

  i2s_array_rx #(.N_LINES(NL), .SAMPLE_W(SW), .SLOT_W(SL), .CLK_DIV(CD), .OUT_W(OW), .CH_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en), .ovf_clr(ovf_clr), .sck(sck), .ws(ws), .sd(sd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .ovf_count(ovf_count)
  );

  int n_checks = 0, n_fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [SW-1:0] words [64][NCH];
  logic [63:0]   expq[$];
  logic [31:0]   first_beats [4];
  logic [63:0]   stall_beat;
  logic [15:0]   exp_cnt = '0;
  logic          mws = 1'b0, busy = 1'b0, active = 1'b0, exp_ovf = 1'b0;
  logic          sck_prev = 1'b0, ws_prev = 1'b0, stall_v = 1'b0, have_rise = 1'b0, have_wsrise = 1'b0;
  int            mode = 0, comp_cnt = 0, stray = 0, stable_err = 0, sck_err = 0, ws_err = 0;
  int            n_wsrise = 0, n_beats = 0, k = 0, mpos = 0, cyc = 0, last_rise = 0, last_wsrise = 0;

  function automatic logic [63:0] beat_of(input int f, input int c);
    logic [SW-1:0] w;
    logic [63:0]   r;
    w = words[f % 64][c];
    r = '0;
    r[31:0]  = w[SW-1] ? 32'(w) + 32'hFF000000 : 32'(w);
    r[33:32] = 2'(c);
    r[34]    = c == NCH - 1;
    return r;
  endfunction

  // microphone model, clock/word-select monitor, frame accounting and stream scoreboard
  initial begin : model
    logic [SW-1:0] w;
    logic [63:0]   obs, e;
    logic          fell;
    forever begin
      @(negedge aclk);
      cyc++;
      fell = sck_prev && !sck;
      if (!aresetn) begin
        active = 0; busy = 0; exp_ovf = 0; exp_cnt = '0; stall_v = 0;
        expq.delete();
      end else begin
        if (ovf_clr) begin exp_ovf = 0; exp_cnt = '0; end
        if (!en) active = 0;
        else if (!active) begin
          active = 1; mpos = 0; mws = 0; have_rise = 0; have_wsrise = 0;
        end
        if (active) begin
          if (sck && !sck_prev) begin
            if (have_rise && cyc - last_rise != 2 * CD) sck_err++;
            have_rise = 1; last_rise = cyc;
          end
          if (ws && !ws_prev) begin
            if (have_wsrise && cyc - last_wsrise != 4 * SL * CD) ws_err++;
            have_wsrise = 1; last_wsrise = cyc; n_wsrise++;
          end
          if (fell) begin
            if (mws && mpos == SW) begin
              comp_cnt++;
              if (!busy) begin
                busy = 1;
                for (int c = 0; c < NCH; c++) expq.push_back(beat_of(k, c));
                check("tvalid_latency", 64'(m_axis_tvalid), 64'd1);
              end else begin
                exp_ovf = 1;
                if (exp_cnt != 16'hFFFF) exp_cnt++;
              end
            end
            if (mpos == SL - 1) begin
              mpos = 0;
              if (mws) k++;
              mws = !mws;
            end else mpos++;
            if (ws !== mws) ws_err++;
            for (int l = 0; l < NL; l++) begin
              w = words[k % 64][2 * l + int'(mws)];
              sd[l] = (mpos >= 1 && mpos <= SW) ? w[SW - mpos] : 1'($urandom);
            end
          end else if (ws !== ws_prev) ws_err++;
        end
        m_axis_tready = mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(0, 99) < 30) : 1'b0;
        obs = {29'b0, m_axis_tlast, m_axis_tuser, m_axis_tdata};
        if (stall_v && (!m_axis_tvalid || obs !== stall_beat)) stable_err++;
        if (m_axis_tvalid && m_axis_tready) begin
          stall_v = 0;
          if (n_beats < 4) first_beats[n_beats] = m_axis_tdata;
          n_beats++;
          if (expq.size() == 0) stray++;
          else begin
            e = expq.pop_front();
            check("beat", obs, e);
            if (e[34]) busy = 0;
          end
        end else begin
          stall_v = m_axis_tvalid;
          stall_beat = obs;
        end
      end
      sck_prev = sck;
      ws_prev = ws;
    end
  end

  task automatic wait_drain(input string tag, input int bound);
    int i = 0;
    while (expq.size() != 0 && i < bound) begin @(posedge aclk); #1; i++; end
    check(tag, 64'(expq.size()), 64'd0);
  endtask

  task automatic wait_comp(input string tag, input int target);
    int i = 0;
    while (comp_cnt < target && i < 1200) begin @(posedge aclk); #1; i++; end
    check(tag, 64'(comp_cnt), 64'(target));
  endtask

  initial begin : stim
    int lat, c0, b0, i;
    for (int f = 0; f < 64; f++)
      for (int c = 0; c < NCH; c++) words[f][c] = SW'($urandom);
    words[0][0] = 24'h123456;
    words[0][1] = 24'h800001;
    words[0][2] = 24'h7FFFFF;
    words[0][3] = 24'h000000;
    aresetn = 0; en = 0; ovf_clr = 0; mode = 1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", 64'({sck, ws, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, overflow, ovf_count}), 64'd0);
    aresetn = 1;
    @(posedge aclk); #1;
    en = 1;
    lat = 0;
    while (!sck && lat < 20) begin @(posedge aclk); #1; lat++; end
    check("sck_rise_latency", 64'(lat), 64'(CD + 1));
    repeat (1700) @(posedge aclk);
    #1;
    wait_drain("drain_basic", 100);
    check("sck_period_err", 64'(sck_err), 64'd0);
    check("ws_err", 64'(ws_err), 64'd0);
    check("ws_rises_seen", 64'(n_wsrise >= 2), 64'd1);
    check("beat0_data", 64'(first_beats[0]), 64'h00123456);
    check("beat1_data", 64'(first_beats[1]), 64'hFF800001);
    check("beat2_data", 64'(first_beats[2]), 64'h007FFFFF);
    check("beat3_data", 64'(first_beats[3]), 64'h00000000);

    mode = 2;
    repeat (2100) @(posedge aclk);
    #1;
    wait_drain("drain_backpressure", 300);
    check("stable_err", 64'(stable_err), 64'd0);
    check("overflow_bp", 64'(overflow), 64'(exp_ovf));
    check("overflow_bp_clear", 64'(overflow), 64'd0);

    mode = 0;
    c0 = comp_cnt;
    wait_comp("comp_wait_ovf", c0 + 2);
    check("held_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("overflow_set", 64'(overflow), 64'(exp_ovf));
    check("ovf_count", 64'(ovf_count), 64'(exp_cnt));
    check("ovf_count_one", 64'(exp_cnt), 64'd1);
    mode = 1;
    wait_drain("drain_held", 100);
    @(posedge aclk); #1;
    ovf_clr = 1;
    @(posedge aclk); #1;
    ovf_clr = 0;
    check("overflow_cleared", 64'({overflow, ovf_count}), 64'({exp_ovf, exp_cnt}));
    check("overflow_cleared_zero", 64'({overflow, ovf_count}), 64'd0);

    i = 0;
    while (!(active && mws && mpos == 10) && i < 1200) begin @(posedge aclk); #1; i++; end
    check("abort_reached", 64'({active, mws}), 64'h3);
    wait_drain("drain_before_abort", 100);
    en = 0;
    @(posedge aclk); #1;
    check("abort_sck_ws", 64'({sck, ws}), 64'd0);
    repeat (600) @(posedge aclk);
    #1;
    check("abort_no_beats", 64'(stray), 64'd0);
    check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    b0 = n_beats;
    c0 = comp_cnt;
    en = 1;
    repeat (1400) @(posedge aclk);
    #1;
    wait_drain("drain_reenable", 100);
    check("frames_after_reenable", 64'(comp_cnt - c0 >= 2), 64'd1);
    check("beats_after_reenable", 64'(n_beats - b0), 64'(4 * (comp_cnt - c0)));

    mode = 0;
    c0 = comp_cnt;
    wait_comp("comp_wait_reset", c0 + 2);
    check("pre_reset_state", 64'({m_axis_tvalid, overflow}), 64'h3);
    #2;
    aresetn = 0;
    en = 0;
    #1;
    check("async_reset_outputs", 64'({m_axis_tvalid, m_axis_tdata, overflow, ovf_count}), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1;
    mode = 1;
    repeat (50) @(posedge aclk);
    #1;
    check("post_reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("stray_beats", 64'(stray), 64'd0);
    check("stable_err_final", 64'(stable_err), 64'd0);
    check("ws_err_final", 64'(ws_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
